// File: rtl/uart_marco_rx_if.sv
// Receive-side bundle between the bit-clock source/line and the MARCO detector.
// The master drives the oversample tick and the line; the slave returns bytes and pulses.
interface uart_marco_rx_if;
  logic       baud16_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       match;

  modport master (
    output baud16_tick,
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  match
  );

  modport slave (
    input  baud16_tick,
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output match
  );
endinterface

// File: rtl/uart_marco_rx.sv
// 8N1 UART receiver with OVERSAMPLE-x line sampling and a streaming "MARCO" matcher
// whose one-clock match pulse feeds the POLO transmitter's send input.
module uart_marco_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_marco_rx_if.slave  bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] C_HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [2:0]    r_prog, w_prog_nxt;
  logic [7:0]    r_rx_data, w_rx_data_nxt;
  logic          r_rx_valid, w_rx_valid_nxt;
  logic          r_frame_err, w_frame_err_nxt;
  logic          r_match, w_match_nxt;
  logic          w_rx_s;
  logic          w_tick;

  function automatic logic [7:0] f_expected(input logic [2:0] p);
    case (p)
      3'd0:    f_expected = 8'h4D;
      3'd1:    f_expected = 8'h41;
      3'd2:    f_expected = 8'h52;
      3'd3:    f_expected = 8'h43;
      default: f_expected = 8'h4F;
    endcase
  endfunction

  assign w_rx_s = r_sync[1];
  assign w_tick = bus.baud16_tick;

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.rx};
    end
  end

  // Next-state, datapath and pulse decode; nothing but pulse clearing moves without a tick.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_nxt       = r_bit;
    w_shift_nxt     = r_shift;
    w_prog_nxt      = r_prog;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_match_nxt     = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt;
          end
        end
        S_START: begin
          if (r_cnt == C_HALF_M1) begin
            w_cnt_nxt = '0;
            if (!w_rx_s) begin
              w_state_nxt = S_DATA;
              w_bit_nxt   = 3'd0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == C_FULL_M1) begin
            w_cnt_nxt   = '0;
            w_shift_nxt = {w_rx_s, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bit_nxt = r_bit + 3'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == C_FULL_M1) begin
            w_cnt_nxt = '0;
            if (w_rx_s) begin
              w_state_nxt    = S_IDLE;
              w_rx_data_nxt  = r_shift;
              w_rx_valid_nxt = 1'b1;
              // A mismatching 'M' still counts as the first letter, so "MMARCO" matches.
              if (r_shift == f_expected(r_prog)) begin
                if (r_prog == 3'd4) begin
                  w_match_nxt = 1'b1;
                  w_prog_nxt  = 3'd0;
                end else begin
                  w_prog_nxt  = r_prog + 3'd1;
                end
              end else if (r_shift == 8'h4D) begin
                w_prog_nxt = 3'd1;
              end else begin
                w_prog_nxt = 3'd0;
              end
            end else begin
              w_state_nxt     = S_BREAK;
              w_frame_err_nxt = 1'b1;
              w_prog_nxt      = 3'd0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          if (w_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_BREAK;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_bit_nxt   = 3'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= 3'd0;
      r_shift     <= 8'h00;
      r_prog      <= 3'd0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_match     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_prog      <= w_prog_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_match     <= w_match_nxt;
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.match     = r_match;

endmodule

// File: tb/tb_uart_marco_rx.sv
// Directed, table-driven bench for uart_marco_rx: each table row is one serial frame
// with the expected pulse counts and held byte; corner cases follow as hand sequences.
module tb_uart_marco_rx;

  logic clk;
  logic rst_n;

  uart_marco_rx_if bus ();

  uart_marco_rx #(.OVERSAMPLE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         hold_low;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
    int         exp_match;
  } vec_t;

  int n_applied = 0;
  int n_miss    = 0;

  int n_valid    = 0;
  int n_ferr     = 0;
  int n_match    = 0;
  int n_match_al = 0;
  int n_both     = 0;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.rx_valid)  n_valid <= n_valid + 1;
    if (bus.frame_err) n_ferr  <= n_ferr + 1;
    if (bus.match)     n_match <= n_match + 1;
    if (bus.match && bus.rx_valid && bus.rx_data == 8'h4F) n_match_al <= n_match_al + 1;
    if (bus.rx_valid && bus.frame_err) n_both <= n_both + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic ticks(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx          = lvl;
      bus.baud16_tick = 1'b1;
      @(negedge clk);
      bus.baud16_tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int hold_low);
    ticks(1'b0, 16);
    for (int b = 0; b < 8; b++) ticks(d[b], 16);
    ticks(stop_ok, 16);
    if (!stop_ok) ticks(1'b0, hold_low);
    ticks(1'b1, 6);
  endtask

  vec_t vecs[24];

  initial begin
    int v0, f0, m0;

    vecs[0]  = '{8'h55, 1'b1, 0, 8'h55, 1, 0, 0};
    vecs[1]  = '{8'hA3, 1'b1, 0, 8'hA3, 1, 0, 0};
    vecs[2]  = '{8'h4D, 1'b1, 0, 8'h4D, 1, 0, 0};
    vecs[3]  = '{8'h41, 1'b1, 0, 8'h41, 1, 0, 0};
    vecs[4]  = '{8'h52, 1'b1, 0, 8'h52, 1, 0, 0};
    vecs[5]  = '{8'h43, 1'b1, 0, 8'h43, 1, 0, 0};
    vecs[6]  = '{8'h4F, 1'b1, 0, 8'h4F, 1, 0, 1};
    vecs[7]  = '{8'h4D, 1'b1, 0, 8'h4D, 1, 0, 0};
    vecs[8]  = '{8'h4D, 1'b1, 0, 8'h4D, 1, 0, 0};
    vecs[9]  = '{8'h41, 1'b1, 0, 8'h41, 1, 0, 0};
    vecs[10] = '{8'h52, 1'b1, 0, 8'h52, 1, 0, 0};
    vecs[11] = '{8'h43, 1'b1, 0, 8'h43, 1, 0, 0};
    vecs[12] = '{8'h4F, 1'b1, 0, 8'h4F, 1, 0, 1};
    vecs[13] = '{8'h4D, 1'b1, 0, 8'h4D, 1, 0, 0};
    vecs[14] = '{8'h41, 1'b1, 0, 8'h41, 1, 0, 0};
    vecs[15] = '{8'h52, 1'b1, 0, 8'h52, 1, 0, 0};
    vecs[16] = '{8'h58, 1'b1, 0, 8'h58, 1, 0, 0};
    vecs[17] = '{8'h4F, 1'b1, 0, 8'h4F, 1, 0, 0};
    vecs[18] = '{8'h4D, 1'b0, 40, 8'h4F, 0, 1, 0};
    vecs[19] = '{8'h4D, 1'b1, 0, 8'h4D, 1, 0, 0};
    vecs[20] = '{8'h41, 1'b1, 0, 8'h41, 1, 0, 0};
    vecs[21] = '{8'h52, 1'b1, 0, 8'h52, 1, 0, 0};
    vecs[22] = '{8'h43, 1'b1, 0, 8'h43, 1, 0, 0};
    vecs[23] = '{8'h4F, 1'b1, 0, 8'h4F, 1, 0, 1};

    bus.rx          = 1'b1;
    bus.baud16_tick = 1'b0;
    rst_n           = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("reset_rx_data",   int'(bus.rx_data),   0);
    chk("reset_rx_valid",  int'(bus.rx_valid),  0);
    chk("reset_frame_err", int'(bus.frame_err), 0);
    chk("reset_match",     int'(bus.match),     0);
    rst_n = 1'b1;

    // Idle line for 200 ticks.
    ticks(1'b1, 200);
    #1;
    chk("idle_rx_data", int'(bus.rx_data), 0);
    chk("idle_valid",   n_valid, 0);
    chk("idle_ferr",    n_ferr,  0);
    chk("idle_match",   n_match, 0);

    // Short low glitch must be rejected at the mid-start sample.
    ticks(1'b0, 3);
    ticks(1'b1, 10);
    #1;
    chk("glitch_valid", n_valid, 0);
    chk("glitch_ferr",  n_ferr,  0);

    for (int i = 0; i < 24; i++) begin
      v0 = n_valid; f0 = n_ferr; m0 = n_match;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].hold_low);
      #1;
      chk($sformatf("vec%0d_rx_data", i),   int'(bus.rx_data), int'(vecs[i].exp_data));
      chk($sformatf("vec%0d_rx_valid", i),  n_valid - v0, vecs[i].exp_valid);
      chk($sformatf("vec%0d_frame_err", i), n_ferr - f0,  vecs[i].exp_ferr);
      chk($sformatf("vec%0d_match", i),     n_match - m0, vecs[i].exp_match);
    end
    chk("match_aligned_with_O", n_match_al, 3);
    chk("valid_ferr_exclusive", n_both, 0);

    // "MARC" then reset during bit 4 of 'O'; a lone 'O' afterwards must not match.
    send_frame(8'h4D, 1'b1, 0);
    send_frame(8'h41, 1'b1, 0);
    send_frame(8'h52, 1'b1, 0);
    send_frame(8'h43, 1'b1, 0);
    v0 = n_valid; f0 = n_ferr; m0 = n_match;
    ticks(1'b0, 16);
    for (int b = 0; b < 4; b++) ticks(bus.rx_data[0] ^ bus.rx_data[0] ^ (8'h4F >> b) & 1'b1, 16);
    ticks(1'b0, 8);
    @(negedge clk);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_rx_data",   int'(bus.rx_data),   0);
    chk("rst_mid_rx_valid",  int'(bus.rx_valid),  0);
    chk("rst_mid_frame_err", int'(bus.frame_err), 0);
    chk("rst_mid_match",     int'(bus.match),     0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ticks(1'b1, 10);
    #1;
    chk("rst_no_pulse_valid", n_valid - v0, 0);
    chk("rst_no_pulse_ferr",  n_ferr - f0,  0);
    send_frame(8'h4F, 1'b1, 0);
    #1;
    chk("post_rst_O_data",  int'(bus.rx_data), 8'h4F);
    chk("post_rst_O_valid", n_valid - v0, 1);
    chk("post_rst_O_match", n_match - m0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
